// File: rtl/quad_enc_gen.sv
// ============================================================================
// quad_enc_gen -- quadrature encoder signal generator
//
// Purpose
//   Emits a two-channel (A/B) quadrature sequence on command. A command names
//   a direction, a number of quarter-phase transitions and the spacing between
//   them in clk cycles. The block keeps a signed 16-bit position that follows
//   every emitted transition. The phase is remembered between commands, so
//   consecutive commands continue the same waveform.
//
//   Optional feature (macro QUAD_BOUNCE_EN):
//     When defined, the line that just changed chatters for BOUNCE_CYC cycles
//     after each transition. The chatter is its clean value XOR bit 0 of a
//     16-bit maximal LFSR that steps every cycle. Periods are then stretched
//     to at least BOUNCE_CYC+1 cycles, so one line settles before the other
//     line moves. Without the macro the outputs are always clean, no LFSR
//     exists and the period is only clamped to a minimum of 1.
//
// Parameters
//   PW          width of the period input
//   BOUNCE_CYC  chatter window length in clk cycles (QUAD_BOUNCE_EN only)
//
// Ports
//   clk        sole clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  command can be accepted (idle and not in reset)
//   cmd_dir    1 = clockwise (A leads B), 0 = counter-clockwise
//   cmd_steps  number of quarter-phase transitions to emit
//   period     clk cycles per transition, sampled on accept
//   abort      stop the running command after the current cycle
//   Aout       quadrature channel A
//   Bout       quadrature channel B
//   busy       command in progress (RUN or FIN)
//   done       one-cycle pulse when a command completes or is aborted
//   pos        signed transition count, wraps modulo 2^16
// ============================================================================
module quad_enc_gen #(
    parameter int PW         = 16,
    parameter int BOUNCE_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_dir,
    input  logic [7:0]    cmd_steps,
    input  logic [PW-1:0] period,
    input  logic          abort,
    output logic          Aout,
    output logic          Bout,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pos
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched command and running counters.
    logic          dir_reg,    dir_next;
    logic [7:0]    steps_reg,  steps_next;
    logic [PW-1:0] period_reg, period_next;
    logic [PW-1:0] timer_reg,  timer_next;

    // Clean phase: bit 1 is A, bit 0 is B.
    logic [1:0]    phase_reg,  phase_next;
    logic [15:0]   pos_reg,    pos_next;

    logic          accept;
    logic          step_due;
    logic          last_step;
    logic [PW-1:0] period_eff;
    logic [1:0]    flip;
    logic [1:0]    noise;
    logic [1:0]    chan;

    assign accept    = cmd_valid && cmd_ready;
    // The timer counts down to zero. A value of 1 here means it reaches
    // zero on this edge, so the transition happens now.
    assign step_due  = (state_reg == RUN) && (timer_reg == PW'(1));
    assign last_step = step_due && (steps_reg == 8'd1);

    // One line toggles per step. Going clockwise, A moves when A==B and B
    // moves otherwise. Going counter-clockwise the roles are swapped.
    assign flip = ((phase_reg[1] == phase_reg[0]) ^ ~dir_reg) ? 2'b10 : 2'b01;

    // ------------------------------------------------------------------
    // Effective period: a zero period would never fire, so treat it as 1.
    // With chatter enabled, stretch short periods past the chatter window.
    // ------------------------------------------------------------------
`ifdef QUAD_BOUNCE_EN
    localparam logic [PW:0] MIN_P = (PW+1)'(BOUNCE_CYC + 1);
`endif

    always_comb begin
        period_eff = (period == '0) ? PW'(1) : period;
`ifdef QUAD_BOUNCE_EN
        if ({1'b0, period_eff} < MIN_P) begin
            period_eff = MIN_P[PW-1:0];
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // A zero-step command goes straight to FIN.
                    state_next = (cmd_steps == 8'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_step || abort) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. These are gated by rst so that a command cut short by
    // reset never shows done or ready during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE:    cmd_ready = 1'b1;
                RUN:     busy      = 1'b1;
                FIN: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: cmd_ready = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        dir_next    = dir_reg;
        steps_next  = steps_reg;
        period_next = period_reg;
        timer_next  = timer_reg;
        phase_next  = phase_reg;
        pos_next    = pos_reg;

        if (accept) begin
            dir_next    = cmd_dir;
            steps_next  = cmd_steps;
            period_next = period_eff;
            timer_next  = period_eff;
        end else if (state_reg == RUN) begin
            if (step_due) begin
                phase_next = phase_reg ^ flip;
                pos_next   = dir_reg ? (pos_reg + 16'd1) : (pos_reg - 16'd1);
                steps_next = steps_reg - 8'd1;
                timer_next = period_reg;
            end else begin
                timer_next = timer_reg - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_reg    <= 1'b0;
            steps_reg  <= 8'd0;
            period_reg <= '0;
            timer_reg  <= '0;
            phase_reg  <= 2'b00;
            pos_reg    <= 16'd0;
        end else begin
            dir_reg    <= dir_next;
            steps_reg  <= steps_next;
            period_reg <= period_next;
            timer_reg  <= timer_next;
            phase_reg  <= phase_next;
            pos_reg    <= pos_next;
        end
    end

    // ------------------------------------------------------------------
    // Contact chatter on the line that just moved
    // ------------------------------------------------------------------
`ifdef QUAD_BOUNCE_EN
    localparam int BW = (BOUNCE_CYC < 1) ? 1 : $clog2(BOUNCE_CYC + 1);

    logic [15:0]   lfsr_reg,       lfsr_next;
    logic [BW-1:0] bounce_cnt_reg, bounce_cnt_next;
    logic [1:0]    bounce_ch_reg,  bounce_ch_next;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5],
                        lfsr_reg[15:1]};

    always_comb begin
        bounce_cnt_next = bounce_cnt_reg;
        bounce_ch_next  = bounce_ch_reg;
        if (step_due) begin
            bounce_cnt_next = BW'(BOUNCE_CYC);
            bounce_ch_next  = flip;
        end else if (bounce_cnt_reg != '0) begin
            bounce_cnt_next = bounce_cnt_reg - BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg       <= 16'hACE1;
            bounce_cnt_reg <= '0;
            bounce_ch_reg  <= 2'b00;
        end else begin
            lfsr_reg       <= lfsr_next;
            bounce_cnt_reg <= bounce_cnt_next;
            bounce_ch_reg  <= bounce_ch_next;
        end
    end

    assign noise = (bounce_cnt_reg != '0) ? (bounce_ch_reg & {2{lfsr_reg[0]}})
                                          : 2'b00;
`else
    // The clean build keeps the parameter only for interface compatibility.
    logic unused_bounce;
    assign unused_bounce = (BOUNCE_CYC != 0);
    assign noise         = 2'b00;
`endif

    // ------------------------------------------------------------------
    // Output channels: clean phase with optional chatter overlay
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        assign chan[gi] = phase_reg[gi] ^ noise[gi];
    end

    assign Aout = chan[1];
    assign Bout = chan[0];
    assign pos  = pos_reg;

endmodule

// File: tb/tb_quad_enc_gen.sv
// ============================================================================
// tb_quad_enc_gen -- self-checking bench for quad_enc_gen
//
// The reference is expressed in terms of elapsed cycles. After the accept
// edge, transition k is due at edge k*P. The position is base +/- the number
// of transitions so far. A/B are a Gray lookup of position mod 4, since the
// position and the phase both start at zero and move together.
// ============================================================================
`timescale 1ns/1ps
module tb_quad_enc_gen;

    localparam int PW = 16;
    localparam int BC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_dir = 1'b0;
    logic [7:0]    cmd_steps = 8'd0;
    logic [PW-1:0] period = '0;
    logic          abort = 1'b0;
    logic          Aout;
    logic          Bout;
    logic          busy;
    logic          done;
    logic [15:0]   pos;

    quad_enc_gen #(.PW(PW), .BOUNCE_CYC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .period    (period),
        .abort     (abort),
        .Aout      (Aout),
        .Bout      (Bout),
        .busy      (busy),
        .done      (done),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_pos = 16'd0;
    logic [1:0]  prev_ab = 2'b00;
    int          last_edge_cyc = -1000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Clockwise Gray order indexed by position mod 4: 00, 10, 11, 01.
    function automatic logic [1:0] ab_of(input logic [15:0] p);
        case (p[1:0])
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_ready", cmd_ready, 0);
            check_eq("rst_done",  done,      0);
            check_eq("rst_busy",  busy,      0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_A",     Aout,      0);
        check_eq("post_rst_B",     Bout,      0);
        check_eq("post_rst_pos",   pos,       0);
        check_eq("post_rst_ready", cmd_ready, 1);
        check_eq("post_rst_done",  done,      0);
        check_eq("post_rst_busy",  busy,      0);
        exp_pos       = 16'd0;
        prev_ab       = 2'b00;
        last_edge_cyc = -1000;
        $display("reset pos=%0h ready=%0d", pos, cmd_ready);
    endtask

    // Issue one command and check every cycle until it is back in IDLE.
    // abort_at is the edge index (relative to accept) at which abort is high.
    // Call this just after a negedge on which the DUT is idle.
    task automatic run_cmd(input logic dir, input int steps, input int per, input int abort_at);
        int          p;
        int          term;
        int          tc;
        int          tr;
        int          prev_tr;
        logic [15:0] base;
        logic [15:0] ep;
        logic [1:0]  ab;
        logic        both;

        p = (per == 0) ? 1 : per;
`ifdef QUAD_BOUNCE_EN
        if (p < BC + 1) p = BC + 1;
`endif
        if (steps == 0)               term = 0;
        else if (abort_at < steps * p) term = abort_at;
        else                          term = steps * p;
        base    = exp_pos;
        prev_tr = 0;

        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_steps = 8'(steps);
        period    = PW'(per);
        abort     = 1'($urandom_range(0, 1));   // ignored while idle
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;

        for (int e = 0; e <= term + 1; e++) begin
            @(negedge clk);
            tc = (e <= term) ? e : term;
            tr = tc / p;
            if (tr > steps) tr = steps;
            if (tr != prev_tr) last_edge_cyc = cyc;
            prev_tr = tr;
            ep = dir ? (base + 16'(tr)) : (base - 16'(tr));
            ab = {Aout, Bout};

            check_eq("pos", pos, ep);
            if (cyc - last_edge_cyc >= BC || last_edge_cyc < 0) begin
                check_eq("ab", ab, ab_of(ep));
            end
`ifndef QUAD_BOUNCE_EN
            if (cyc - last_edge_cyc < BC && last_edge_cyc >= 0) begin
                check_eq("ab", ab, ab_of(ep));
            end
`endif
            both = (ab[1] != prev_ab[1]) && (ab[0] != prev_ab[0]);
            check_eq("ab_one_line", both, 0);
            prev_ab = ab;

            check_eq("done",  done,      (e == term) ? 1 : 0);
            check_eq("busy",  busy,      (e <= term) ? 1 : 0);
            check_eq("ready", cmd_ready, (e >  term) ? 1 : 0);

            // Drive the inputs for the next edge.
            if (e + 1 == abort_at && e + 1 <= term) abort = 1'b1;
            else if (e + 1 > term)                  abort = 1'($urandom_range(0, 1));
            else                                    abort = 1'b0;
            if (e + 1 <= term + 1) begin
                // Everything here must be ignored while busy.
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_dir   = 1'($urandom_range(0, 1));
                cmd_steps = 8'($urandom_range(0, 255));
                period    = PW'($urandom_range(0, 65535));
            end else begin
                cmd_valid = 1'b0;
            end
        end
        exp_pos = dir ? (base + 16'(prev_tr)) : (base - 16'(prev_tr));
        $display("cmd dir=%0d steps=%0d period=%0d abort_at=%0d edges=%0d pos=%0h",
                 dir, steps, per, (abort_at > 100000) ? -1 : abort_at, prev_tr, pos);
        cmd_valid = 1'b0;
    endtask

    localparam int NO_ABORT = 1 << 30;

    initial begin
        int st;
        int pr;
        int ab_at;

        do_reset();

        // Directed sequences.
        run_cmd(1'b1, 4, 10, NO_ABORT);
        check_eq("cw4_pos", pos, 16'd4);
        run_cmd(1'b0, 5, 1, NO_ABORT);
        check_eq("ccw5_pos", pos, 16'hFFFF);
        run_cmd(1'b1, 0, 0, NO_ABORT);
        check_eq("zero_pos", pos, 16'hFFFF);

        do_reset();
        run_cmd(1'b1, 200, 3, 22);
        check_eq("abort_pos", pos, 16'd7);

        // Randomised commands.
        for (int k = 0; k < 30; k++) begin
            st = $urandom_range(0, 30);
            pr = $urandom_range(0, 6);
            ab_at = NO_ABORT;
            if (st > 0 && $urandom_range(0, 3) == 0) begin
                ab_at = $urandom_range(1, st * ((pr == 0) ? 1 : pr));
            end
            run_cmd(1'($urandom_range(0, 1)), st, pr, ab_at);
        end

        // Reset in the middle of a command: no done pulse, everything cleared.
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_steps = 8'd50;
        period    = PW'(2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check_eq("mid_done", done, 0);
        end
        do_reset();

        run_cmd(1'b0, 3, 2, NO_ABORT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 SHALL have parameter PW, default 16, meaning width of the quarter-phase period input.
REQ-002 SHALL have parameter BOUNCE_CYC, default 16, meaning bounce window length in clk cycles (used only under QUAD_BOUNCE_EN).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  step command offered.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  direction: 1 = clockwise (A leads B), 0 = counter-clockwise.
REQ-008 SHALL have port cmd_steps  input  8  number of quarter-phase transitions to emit.
REQ-009 SHALL have port period  input  PW  clk cycles per transition, sampled on command accept.
REQ-010 SHALL have port abort  input  1  terminate the running command.
REQ-011 SHALL have port Aout  output  1  quadrature channel A.
REQ-012 SHALL have port Bout  output  1  quadrature channel B.
REQ-013 SHALL have port busy  output  1  command in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at command completion or abort.
REQ-015 SHALL have port pos  output  16  signed transition count, wraps modulo 2^16.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FIN; cmd_ready = 1 only in IDLE; busy = 1 in RUN and FIN.
REQ-017 SHALL accept a command when cmd_valid && cmd_ready; it SHALL latch cmd_dir, cmd_steps, and max(period,1), load the timer, and enter RUN on the next cycle.
REQ-018 SHALL hold the clean phase as 2-bit Gray state AB: clockwise order 00->10->11->01->00; counter-clockwise is the reverse.
REQ-019 SHALL, in RUN, decrement the timer each cycle; on the cycle it reaches 0 it SHALL advance the phase one step, change pos by +1 (cw) or -1 (ccw), decrement steps_left, and reload the timer.
REQ-020 SHALL emit the first transition exactly P cycles after the accept cycle, and each later transition P cycles after the previous one (P = latched period).
REQ-021 SHALL move to FIN on the cycle steps_left reaches 0; FIN SHALL assert done for exactly one cycle and return to IDLE.
REQ-022 SHALL, for cmd_steps = 0, go accept -> FIN -> IDLE with no transition and no change to pos.
REQ-023 SHALL, when abort is high in RUN, go to FIN next cycle with Aout, Bout, and pos holding their current values; a transition due in that same cycle SHALL still occur.
REQ-024 SHALL ignore abort in IDLE and FIN.
REQ-025 SHALL never change Aout and Bout in the same cycle (clean outputs).
REQ-026 SHALL ignore inputs other than cmd_valid and abort while busy; the phase SHALL persist across commands.

Reset
REQ-027 SHALL, on rst, drive state = IDLE, Aout = 0, Bout = 0, pos = 0, done = 0, busy = 0, timer = 0, steps_left = 0.
REQ-028 SHALL hold cmd_ready = 0 while rst is high.
REQ-029 SHALL, on rst mid-command, abandon the command with no done pulse.

Configuration
REQ-030 SHALL use macro QUAD_BOUNCE_EN: when defined, for BOUNCE_CYC cycles after each transition, the channel that just changed SHALL equal its clean value XOR bit 0 of a 16-bit maximal LFSR (seed 16'hACE1 on rst, stepping every cycle), then settle to the clean value; the other channel stays clean.
REQ-031 SHALL, under QUAD_BOUNCE_EN, treat latched P values below BOUNCE_CYC+1 as BOUNCE_CYC+1.
REQ-032 SHALL, without QUAD_BOUNCE_EN, emit clean outputs only, include no LFSR logic, and apply no period clamp.

Verification
REQ-033 Reset -> Aout = 0, Bout = 0, pos = 0, cmd_ready = 1 on the first cycle after rst falls.
REQ-034 cmd dir=1, steps=4, period=10 -> AB sequence 10, 11, 01, 00 at accept+10/20/30/40; pos = 4; done one cycle after the 4th edge.
REQ-035 Then dir=0, steps=5, period=1 -> AB 01, 11, 10, 00, 01 on consecutive cycles; pos = -1 (16'hFFFF).
REQ-036 steps=0, period=0 -> no edge, done pulse one cycle after FIN entry, pos unchanged.
REQ-037 steps=200, period=3, abort after 7 edges -> pos = +7, outputs frozen, done pulses once, cmd_ready returns.
REQ-038 With QUAD_BOUNCE_EN, steps=8, period=4 -> effective spacing 17 cycles, changed line toggles only within 16 cycles after each edge, and final AB matches clean sequence.
